regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the decode stage; next generation of the 2R/1W file.
//  NUM_RD combinational read ports and two write ports (WB0 = older, WB1 = younger).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_rd_port.sv | 43 ++++
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and init FSM encoding for the
// multi-port decode-stage register file.
package regfile_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_NUM = 32;
    localparam int DEF_NUM_RD  = 2;

    // Address width for a file of n registers; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // CLEAR = post-reset zeroing sweep, RUN = file usable.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } init_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: gating, write-to-read bypass (younger
// writeback first) and busy masking of the scoreboard bit.
module regfile_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              init_done,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] word,
    input  logic              sb_bit,
    output logic [DATA_W-1:0] rdata_i,
    output logic              rbusy_i
);

    logic hit0;
    logic hit1;
    logic active;

    assign hit0   = we0 && (waddr0 == addr);
    assign hit1   = we1 && (waddr1 == addr);
    assign active = init_done && re && (addr != '0);

    // Select read data: gated to zero, else younger write, older write, array.
    always_comb begin
        rdata_i = '0;
        if (active) begin
            if (hit1)      rdata_i = wdata1;
            else if (hit0) rdata_i = wdata0;
            else           rdata_i = word;
        end
    end

    // A write landing this cycle supplies the operand, so it is no longer pending.
    assign rbusy_i = init_done && re && sb_bit && !hit0 && !hit1;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD bypassed read ports, two
// writeback ports (port 1 younger, wins on collision), busy scoreboard,
// and a post-reset sweep that zeroes every register before init_done.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_NUM = DEF_REG_NUM,
    parameter int NUM_RD  = DEF_NUM_RD
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_done,
    input  logic                       we0,
    input  logic [addr_w(REG_NUM)-1:0] waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [addr_w(REG_NUM)-1:0] waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*addr_w(REG_NUM)-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       sb_set,
    input  logic [addr_w(REG_NUM)-1:0] sb_addr
);

    localparam int ADDR_W = addr_w(REG_NUM);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

    logic [DATA_W-1:0]  regs [REG_NUM];
    logic [REG_NUM-1:0] sb;
    logic [REG_NUM-1:0] sb_next;
    logic [ADDR_W-1:0]  idx;
    init_state_t        state;

    // Init FSM: reset parks in CLEAR at index 0; sweep one register per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            idx       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    idx <= idx + ADDR_W'(1);
                    if (idx == LAST_IDX) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage: sweep zeroing while clearing, architectural writes once running.
    // Port 1 is applied last so it wins an address collision; r0 is never written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[idx] <= '0;
            end else if (init_done) begin
                if (we0 && waddr0 != '0) regs[waddr0] <= wdata0;
                if (we1 && waddr1 != '0) regs[waddr1] <= wdata1;
            end
        end
    end

    // Scoreboard next state: writebacks clear, a new producer sets (set wins).
    always_comb begin
        sb_next = sb;
        if (we0) sb_next[waddr0] = 1'b0;
        if (we1) sb_next[waddr1] = 1'b0;
        if (sb_set && sb_addr != '0) sb_next[sb_addr] = 1'b1;
        sb_next[0] = 1'b0;
    end

    // Scoreboard register: cleared on reset, frozen until the sweep completes.
    always_ff @(posedge clk) begin
        if (rst)            sb <= '0;
        else if (init_done) sb <= sb_next;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[i*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .init_done (init_done),
            .re        (re[i]),
            .addr      (ra),
            .we0       (we0),
            .waddr0    (waddr0),
            .wdata0    (wdata0),
            .we1       (we1),
            .waddr1    (waddr1),
            .wdata1    (wdata1),
            .word      (regs[ra]),
            .sb_bit    (sb[ra]),
            .rdata_i   (rdata[i*DATA_W +: DATA_W]),
            .rbusy_i   (rbusy[i])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset sweep timing, bypass, r0 handling,
// scoreboard set/clear ordering and reset restart mid-sweep.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          we0, we1, sb_set;
    logic [AW-1:0] waddr0, waddr1, sb_addr;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    re;
    logic [2*AW-1:0] raddr;
    logic [2*DW-1:0] rdata;
    logic [1:0]    rbusy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .REG_NUM(32), .NUM_RD(2)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .sb_set(sb_set), .sb_addr(sb_addr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 0; waddr0 = '0; wdata0 = '0;
        we1 = 0; waddr1 = '0; wdata1 = '0;
        sb_set = 0; sb_addr = '0;
    endtask

    task automatic set_rd(input logic [1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        re = r;
        raddr = {a1, a0};
    endtask

    // Count rising edges after rst release until init_done; checks reads stay 0.
    task automatic wait_init(input string name, output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (init_done) break;
            if (n == 3) begin
                chk({name, "_rd_sweep"}, rdata, 64'h0);
                chk({name, "_busy_sweep"}, {62'h0, rbusy}, 64'h0);
            end
        end
    endtask

    typedef struct {
        logic we0; logic [AW-1:0] wa0; logic [DW-1:0] wd0;
        logic we1; logic [AW-1:0] wa1; logic [DW-1:0] wd1;
        logic sbs; logic [AW-1:0] sba;
        logic [1:0] re; logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] e0, e1; logic [1:0] eb;
    } vec_t;

    function automatic vec_t mk(
        input logic w0, input int a0, input logic [DW-1:0] d0,
        input logic w1, input int a1, input logic [DW-1:0] d1,
        input logic ss, input int sa,
        input logic [1:0] r, input int r0, input int r1,
        input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [1:0] eb);
        vec_t v;
        v.we0 = w0; v.wa0 = AW'(a0); v.wd0 = d0;
        v.we1 = w1; v.wa1 = AW'(a1); v.wd1 = d1;
        v.sbs = ss; v.sba = AW'(sa);
        v.re = r; v.ra0 = AW'(r0); v.ra1 = AW'(r1);
        v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    vec_t vt [19];
    int   n;

    initial begin
        //          we0 a0 d0           we1 a1 d1     sb  sa  re    r0  r1  e0            e1       eb
        vt[0]  = mk(1, 3, 32'h11,       1, 3, 32'h22, 0, 0, 2'b01, 3,  0, 32'h22,       32'h0,   2'b00);
        vt[1]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 2'b11, 3,  3, 32'h22,       32'h22,  2'b00);
        vt[2]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,      0, 0, 2'b11, 0,  0, 32'h0,        32'h0,   2'b00);
        vt[3]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 2'b11, 0,  0, 32'h0,        32'h0,   2'b00);
        vt[4]  = mk(0, 0, 0,            0, 0, 0,      1, 7, 2'b11, 7,  3, 32'h0,        32'h22,  2'b00);
        vt[5]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 2'b11, 7,  7, 32'h0,        32'h0,   2'b11);
        vt[6]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 2'b01, 7,  7, 32'h0,        32'h0,   2'b01);
        vt[7]  = mk(1, 7, 32'h55,       0, 0, 0,      0, 0, 2'b11, 7,  7, 32'h55,       32'h55,  2'b00);
        vt[8]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 2'b11, 7,  7, 32'h55,       32'h55,  2'b00);
        vt[9]  = mk(0, 0, 0,            1, 9, 32'h99, 1, 9, 2'b11, 9,  9, 32'h99,       32'h99,  2'b00);
        vt[10] = mk(0, 0, 0,            0, 0, 0,      0, 0, 2'b11, 9,  9, 32'h99,       32'h99,  2'b11);
        vt[11] = mk(0, 0, 0,            1, 9, 32'hAA, 0, 0, 2'b11, 9,  5, 32'hAA,       32'h0,   2'b00);
        vt[12] = mk(0, 0, 0,            0, 0, 0,      0, 0, 2'b11, 9,  9, 32'hAA,       32'hAA,  2'b00);
        vt[13] = mk(0, 0, 0,            0, 0, 0,      1, 0, 2'b11, 0,  0, 32'h0,        32'h0,   2'b00);
        vt[14] = mk(0, 0, 0,            0, 0, 0,      0, 0, 2'b11, 0,  0, 32'h0,        32'h0,   2'b00);
        vt[15] = mk(1, 10, 32'h1010,    1, 11, 32'h1111, 0, 0, 2'b11, 10, 11, 32'h1010, 32'h1111, 2'b00);
        vt[16] = mk(1, 12, 32'hC0,      1, 10, 32'hB0, 0, 0, 2'b11, 10, 12, 32'hB0,     32'hC0,  2'b00);
        vt[17] = mk(0, 0, 0,            0, 0, 0,      0, 0, 2'b11, 10, 12, 32'hB0,      32'hC0,  2'b00);
        vt[18] = mk(0, 0, 0,            0, 0, 0,      0, 0, 2'b00, 10, 12, 32'h0,       32'h0,   2'b00);

        // Power-on reset and first sweep.
        rst = 1; idle(); set_rd(2'b11, 5, 5);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_init_done", {63'h0, init_done}, 64'h0);
        chk("rst_rdata", rdata, 64'h0);
        @(negedge clk); rst = 0;
        wait_init("sweep1", n);
        chk("sweep1_cycles", 64'(n), 64'd32);

        // Preload r5, confirm it, then reset and confirm the sweep wiped it.
        @(negedge clk); we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
        @(negedge clk); idle(); #1;
        chk("preload_r5", {32'h0, rdata[DW-1:0]}, 64'hDEADBEEF);
        rst = 1;
        @(posedge clk); #1;
        chk("pulse_init_done", {63'h0, init_done}, 64'h0);
        @(negedge clk); rst = 0;
        wait_init("sweep2", n);
        chk("sweep2_cycles", 64'(n), 64'd32);
        @(negedge clk); #1;
        chk("r5_zeroed", rdata, 64'h0);

        // Table vectors: drive at negedge, check combinational outputs before the edge.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            we0 = vt[i].we0; waddr0 = vt[i].wa0; wdata0 = vt[i].wd0;
            we1 = vt[i].we1; waddr1 = vt[i].wa1; wdata1 = vt[i].wd1;
            sb_set = vt[i].sbs; sb_addr = vt[i].sba;
            set_rd(vt[i].re, vt[i].ra0, vt[i].ra1);
            #1;
            chk($sformatf("v%0d_rdata0", i), {32'h0, rdata[DW-1:0]}, {32'h0, vt[i].e0});
            chk($sformatf("v%0d_rdata1", i), {32'h0, rdata[2*DW-1:DW]}, {32'h0, vt[i].e1});
            chk($sformatf("v%0d_rbusy", i), {62'h0, rbusy}, {62'h0, vt[i].eb});
        end

        // Leave r13 busy, then reset: scoreboard must come back clear.
        @(negedge clk); idle(); sb_set = 1; sb_addr = 13;
        @(negedge clk); idle(); set_rd(2'b11, 13, 13); #1;
        chk("r13_busy", {62'h0, rbusy}, 64'h3);

        // Reset, let the sweep reach idx 10 with writes pending, then restart it.
        rst = 1;
        @(negedge clk); rst = 0; we0 = 1; waddr0 = 4; wdata0 = 32'h44;
        set_rd(2'b11, 4, 10);
        for (int k = 0; k < 10; k++) @(posedge clk);
        #1;
        chk("mid_sweep_init_done", {63'h0, init_done}, 64'h0);
        chk("mid_sweep_rdata", rdata, 64'h0);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        for (int k = 0; k < 5; k++) @(posedge clk);
        @(negedge clk); idle();
        for (int k = 0; k < 26; k++) @(posedge clk);
        #1;
        chk("restart_31_edges", {63'h0, init_done}, 64'h0);
        @(posedge clk); #1;
        chk("restart_32_edges", {63'h0, init_done}, 64'h1);
        @(negedge clk); #1;
        chk("sweep_write_lost", {32'h0, rdata[DW-1:0]}, 64'h0);
        chk("r10_zeroed", {32'h0, rdata[2*DW-1:DW]}, 64'h0);
        set_rd(2'b11, 13, 13); #1;
        chk("sb_cleared_by_rst", {62'h0, rbusy}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
